mem_responder: RTL and testbench

Synthesizable memory-side responder for the LC-3b `mem_read` / `mem_write` / `mem_resp` interface driven by the CPU datapath and control pair. It answers each CPU read or write with a single-cycle `mem_resp` after a fixed, parameterized latency, and holds a word-organized storage array with byte-write enables. It sits at the top level opposite the CPU and replaces the behavioural test memory in synthesizable builds.

---
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory-side responder for the LC-3b
// mem_read / mem_write / mem_resp handshake. Storage is a word array with
// byte-lane write enables. Every transaction walks IDLE -> BUSY -> RESP -> TURN.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;

  // Captured request. idx is the word index; wr=0 means read.
  typedef struct packed {
    logic                  wr;
    logic [1:0]            be;
    logic [ADDR_WIDTH-1:0] idx;
    logic [15:0]           wdata;
  } req_t;

  // BUSY spans cycles 1..LATENCY-1. The counter is loaded so that it reaches
  // zero in the last BUSY cycle, and RESP is entered on the following edge.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        accept;
  logic        commit;
  req_t        live_req, cap_req, op_req;
  logic [15:0] mem [2**ADDR_WIDTH];

  // Address bits outside the word index are intentionally ignored, so
  // addresses alias.
  logic unused_addr;
  assign unused_addr = ^{mem_address[15:ADDR_WIDTH+1], mem_address[0]};

  // Request as presented on the pins. A write wins when both requests are high.
  assign live_req.wr    = mem_write;
  assign live_req.be    = mem_byte_enable;
  assign live_req.idx   = mem_address[ADDR_WIDTH:1];
  assign live_req.wdata = mem_wdata;

  // When LATENCY=1 the request commits on the same edge that accepts it, so
  // the live pins are used in IDLE. Otherwise the captured copy is used.
  assign op_req = (state == IDLE) ? live_req : cap_req;

  // Completion is visible for the whole RESP cycle, which is registered state.
  assign mem_resp = (state == RESP);

  // Next-state and counter logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept  = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_n = RESP;
        else             cnt_n   = cnt - 4'd1;
      end
      RESP:    state_n = TURN;
      TURN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // The array or rdata is updated on the edge that enters RESP. Reset on
    // that edge aborts the transaction.
    commit = (state_n == RESP) && (state != RESP) && !reset;
  end

  // State register, counter, and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_rdata <= 16'h0000;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (commit && !op_req.wr) mem_rdata <= mem[op_req.idx];
    end
  end

  // Request capture. Inputs are ignored outside IDLE.
  always_ff @(posedge clk) begin
    if (accept && !reset) cap_req <= live_req;
  end

  // Byte-lane writes into the array. Reset does not clear the contents.
  always_ff @(posedge clk) begin
    if (commit && op_req.wr) begin
      if (op_req.be[0]) mem[op_req.idx][7:0]  <= op_req.wdata[7:0];
      if (op_req.be[1]) mem[op_req.idx][15:8] <= op_req.wdata[15:8];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=3 instance for the functional
// sequence, plus LATENCY=1/2/7 instances for the held-request spacing sweep.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  logic        sw_reset, sw_read;
  logic [15:0] sw_addr;
  logic [15:0] sw_rdata1, sw_rdata2, sw_rdata7;
  logic        sw_resp1, sw_resp2, sw_resp7;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(sw_reset), .mem_read(sw_read), .mem_write(1'b0),
    .mem_byte_enable(2'b11), .mem_address(sw_addr), .mem_wdata(16'h0000),
    .mem_rdata(sw_rdata1), .mem_resp(sw_resp1)
  );

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(sw_reset), .mem_read(sw_read), .mem_write(1'b0),
    .mem_byte_enable(2'b11), .mem_address(sw_addr), .mem_wdata(16'h0000),
    .mem_rdata(sw_rdata2), .mem_resp(sw_resp2)
  );

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(7)) u_l7 (
    .clk(clk), .reset(sw_reset), .mem_read(sw_read), .mem_write(1'b0),
    .mem_byte_enable(2'b11), .mem_address(sw_addr), .mem_wdata(16'h0000),
    .mem_rdata(sw_rdata7), .mem_resp(sw_resp7)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after the posedge that starts cycle 0 with a request driven.
  // Returns the cycle of mem_resp (-1 on timeout) and rdata in that cycle.
  // The request stays high through the TURN cycle, where no resp may appear,
  // then drops; on return the next request can be driven immediately.
  task automatic wait_resp(output int rc, output logic [15:0] rd);
    rc = -1;
    rd = 16'hxxxx;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_resp) begin
        rc = k;
        rd = mem_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (rc < 0) chk("resp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("turn_no_resp", {31'd0, mem_resp}, 32'd0);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic xact(input logic rd_en, input logic wr_en, input logic [1:0] be,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      output int rc, output logic [15:0] rd);
    mem_read        = rd_en;
    mem_write       = wr_en;
    mem_byte_enable = be;
    mem_address     = addr;
    mem_wdata       = wdata;
    wait_resp(rc, rd);
  endtask

  function automatic logic exp_resp(input int c, input int l);
    return (c >= l) && (((c - l) % (l + 2)) == 0);
  endfunction

  initial begin
    int          rc, n;
    logic [15:0] rd;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_address = 16'h0000; mem_wdata = 16'h0000;
    sw_reset = 1'b1; sw_read = 1'b0; sw_addr = 16'h0000;

    // Reset state, checked while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp", {31'd0, mem_resp}, 32'd0);
    chk("rst_rdata", {16'd0, mem_rdata}, 32'h0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Preload word 5, then a held read at 0x000A.
    xact(1'b0, 1'b1, 2'b11, 16'h000A, 16'hBEEF, rc, rd);
    chk("preload_lat", rc, 3);
    xact(1'b1, 1'b0, 2'b00, 16'h000A, 16'h0000, rc, rd);
    chk("read_lat", rc, 3);
    chk("read_data", {16'd0, rd}, 32'hBEEF);

    // Byte-lane writes.
    xact(1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, rc, rd);
    xact(1'b0, 1'b1, 2'b10, 16'h0020, 16'hAB00, rc, rd);
    xact(1'b0, 1'b1, 2'b01, 16'h0020, 16'h00CD, rc, rd);
    xact(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, rc, rd);
    chk("be_merge", {16'd0, rd}, 32'hABCD);
    xact(1'b0, 1'b1, 2'b00, 16'h0020, 16'hFFFF, rc, rd);
    chk("be00_lat", rc, 3);
    xact(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, rc, rd);
    chk("be00_data", {16'd0, rd}, 32'hABCD);

    // Simultaneous read+write is a write; rdata untouched. Alias read.
    xact(1'b1, 1'b1, 2'b11, 16'h0002, 16'h5555, rc, rd);
    chk("both_lat", rc, 3);
    chk("both_rdata_kept", {16'd0, mem_rdata}, 32'hABCD);
    xact(1'b1, 1'b0, 2'b00, 16'h0202, 16'h0000, rc, rd);
    chk("alias_data", {16'd0, rd}, 32'h5555);

    // Reset abort on the cycle before RESP entry.
    xact(1'b0, 1'b1, 2'b11, 16'h0004, 16'h1111, rc, rd);
    mem_write = 1'b1; mem_byte_enable = 2'b11;
    mem_address = 16'h0004; mem_wdata = 16'h7777;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_resp) n++;
      @(posedge clk); #1;
    end
    chk("abort_no_resp", n, 0);
    chk("abort_rdata_rst", {16'd0, mem_rdata}, 32'h0000);
    xact(1'b1, 1'b0, 2'b00, 16'h0004, 16'h0000, rc, rd);
    chk("abort_old_data", {16'd0, rd}, 32'h1111);

    // Inputs changed during BUSY are ignored.
    xact(1'b0, 1'b1, 2'b11, 16'h0042, 16'h0F0F, rc, rd);
    mem_write = 1'b1; mem_byte_enable = 2'b11;
    mem_address = 16'h0040; mem_wdata = 16'h2468;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_byte_enable = 2'b01;
    mem_address = 16'h0042; mem_wdata = 16'h9999;
    wait_resp(rc, rd);
    chk("busy_chg_lat", rc, 2);
    xact(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, rc, rd);
    chk("busy_chg_dst", {16'd0, rd}, 32'h2468);
    xact(1'b1, 1'b0, 2'b00, 16'h0042, 16'h0000, rc, rd);
    chk("busy_chg_other", {16'd0, rd}, 32'h0F0F);

    // Latency sweep with a continuously held read and a wandering address.
    @(posedge clk); #1;
    sw_reset = 1'b0;
    @(posedge clk); #1;
    sw_read = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("sweep_L1", {31'd0, sw_resp1}, {31'd0, exp_resp(c, 1)});
      chk("sweep_L2", {31'd0, sw_resp2}, {31'd0, exp_resp(c, 2)});
      chk("sweep_L7", {31'd0, sw_resp7}, {31'd0, exp_resp(c, 7)});
      @(posedge clk); #1;
      sw_addr = 16'(c * 2 + 2);
    end
    sw_read = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
